sram_port_arbiter: RTL and testbench

- Shares one synchronous SRAM port between the instruction-fetch requester and the data-access requester of the 5-stage MIPS32 core.
- Grants at most one access per cycle and tracks the single outstanding read so that returned data is routed to the requester that issued it.
- Raises stall requests toward the stall control unit whenever a requester is refused.
- Data accesses normally win arbitration. A starvation counter guarantees that instruction fetch makes forward progress.

---
 rtl/sram_port_arbiter.sv | 98 +++++++++
 tb/tb_sram_port_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// Shares one synchronous SRAM port between instruction fetch and data access.
// Data wins by default; a starvation counter forces an instruction grant.
module sram_port_arbiter #(
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst,
  input  logic        flush,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic [3:0]  d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        sram_en,
  output logic [3:0]  sram_we,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata,
  output logic        stallreq_if,
  output logic        stallreq_mem
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state;
  logic [1:0]    cnt;
  logic [SW-1:0] starve;
  logic          owner;
  logic          squash;
  logic          live;

  logic act, done, elig, pick_i, rd_gnt;

  // live is low during reset and the first cycle after, muting every output
  assign act    = live & ~cpu_rst;
  assign done   = (state == BUSY) && (cnt == 2'(RD_LAT - 1));
  assign elig   = act & ((state == IDLE) | done);
  assign pick_i = i_req & (~d_req | (starve == SW'(STARVE_MAX)));

  assign i_gnt  = elig & pick_i;
  assign d_gnt  = elig & d_req & ~pick_i;
  assign rd_gnt = i_gnt | (d_gnt & (d_we == 4'd0));

  assign sram_en    = i_gnt | d_gnt;
  assign sram_we    = d_gnt ? d_we : 4'd0;
  assign sram_addr  = d_gnt ? d_addr : (i_gnt ? i_addr : 32'd0);
  assign sram_wdata = d_gnt ? d_wdata : 32'd0;

  // a flush landing on the completion cycle still kills the instruction word
  assign i_rvalid = act & done & (owner == OWN_I) & ~squash & ~flush;
  assign d_rvalid = act & done & (owner == OWN_D);
  assign i_rdata  = i_rvalid ? sram_rdata : 32'd0;
  assign d_rdata  = d_rvalid ? sram_rdata : 32'd0;

  assign stallreq_if  = act & i_req & ~i_gnt;
  assign stallreq_mem = act & ((d_req & ~d_gnt) |
                               ((state == BUSY) & (owner == OWN_D) & ~d_rvalid));

  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      state  <= IDLE;
      cnt    <= 2'd0;
      starve <= '0;
      owner  <= OWN_I;
      squash <= 1'b0;
      live   <= 1'b0;
    end else begin
      live <= 1'b1;
      if (rd_gnt) begin
        state  <= BUSY;
        cnt    <= 2'd0;
        owner  <= d_gnt ? OWN_D : OWN_I;
        squash <= i_gnt & flush;
      end else if (done) begin
        state  <= IDLE;
        cnt    <= 2'd0;
        squash <= 1'b0;
      end else if (state == BUSY) begin
        cnt <= cnt + 2'd1;
        if (flush && owner == OWN_I) squash <= 1'b1;
      end

      if (!act || flush || !i_req || i_gnt) starve <= '0;
      else if (starve != SW'(STARVE_MAX))   starve <= starve + SW'(1);
    end
  end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter: three instances at RD_LAT 1, 2, 3,
// each with a small SRAM model; read returns are checked by a negedge monitor.
module tb_sram_port_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        flush [3], i_req [3], i_gnt [3], i_rvalid [3];
  logic        d_req [3], d_gnt [3], d_rvalid [3], sram_en [3];
  logic        stallreq_if [3], stallreq_mem [3];
  logic [31:0] i_addr [3], i_rdata [3], d_addr [3], d_wdata [3], d_rdata [3];
  logic [31:0] sram_addr [3], sram_wdata [3], sram_rdata [3];
  logic [3:0]  d_we [3], sram_we [3];

  int ntests = 0;
  int nfail  = 0;

  typedef struct {
    int          inst;
    bit          is_d;
    logic [31:0] data;
  } exp_t;
  exp_t sb [$];

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    case (a)
      32'hBFC0_0000: mem_f = 32'h2401_0001;
      32'hBFC0_0004: mem_f = 32'h2402_0002;
      default:       mem_f = a ^ 32'hA5A5_A5A5;
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : gen_dut
    logic [31:0] pipe [4];
    always @(posedge clk) begin
      pipe[0] <= (sram_en[g] && sram_we[g] == 4'd0) ? mem_f(sram_addr[g]) : 32'd0;
      for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
    end
    assign sram_rdata[g] = pipe[g];

    sram_port_arbiter #(.RD_LAT(g + 1), .STARVE_MAX(4)) u_dut (
      .cpu_clk_50M (clk),
      .cpu_rst     (rst),
      .flush       (flush[g]),
      .i_req       (i_req[g]),
      .i_addr      (i_addr[g]),
      .i_gnt       (i_gnt[g]),
      .i_rvalid    (i_rvalid[g]),
      .i_rdata     (i_rdata[g]),
      .d_req       (d_req[g]),
      .d_we        (d_we[g]),
      .d_addr      (d_addr[g]),
      .d_wdata     (d_wdata[g]),
      .d_gnt       (d_gnt[g]),
      .d_rvalid    (d_rvalid[g]),
      .d_rdata     (d_rdata[g]),
      .sram_en     (sram_en[g]),
      .sram_we     (sram_we[g]),
      .sram_addr   (sram_addr[g]),
      .sram_wdata  (sram_wdata[g]),
      .sram_rdata  (sram_rdata[g]),
      .stallreq_if (stallreq_if[g]),
      .stallreq_mem(stallreq_mem[g])
    );
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input int inst, input bit is_d, input logic [31:0] data);
    exp_t e;
    e.inst = inst; e.is_d = is_d; e.data = data;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    for (int g = 0; g < 3; g++) begin
      flush[g] = 1'b0; i_req[g] = 1'b0; d_req[g] = 1'b0; d_we[g] = 4'd0;
      i_addr[g] = 32'd0; d_addr[g] = 32'd0; d_wdata[g] = 32'd0;
    end
  endtask

  function automatic logic [31:0] outs_or(input int g);
    outs_or = {31'd0, |{i_gnt[g], i_rvalid[g], i_rdata[g], d_gnt[g], d_rvalid[g],
                        d_rdata[g], sram_en[g], sram_we[g], sram_addr[g],
                        sram_wdata[g], stallreq_if[g], stallreq_mem[g]}};
  endfunction

  // read-return monitor
  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (i_rvalid[g] || d_rvalid[g]) begin
        ntests++;
        if (sb.size() == 0) begin
          nfail++;
          $display("FAIL sb_unexpected inst%0d: i_rvalid=%0b d_rvalid=%0b with no expected read",
                   g, i_rvalid[g], d_rvalid[g]);
        end else begin
          exp_t e;
          logic [31:0] got;
          e = sb.pop_front();
          got = d_rvalid[g] ? d_rdata[g] : i_rdata[g];
          if (e.inst != g || e.is_d != d_rvalid[g] || i_rvalid[g] == d_rvalid[g] || got !== e.data) begin
            nfail++;
            $display("FAIL sb_return: got inst%0d d=%0b data=%h expected inst%0d d=%0b data=%h",
                     g, d_rvalid[g], got, e.inst, e.is_d, e.data);
          end
        end
      end
    end
  end

  initial begin
    clr();
    rst = 1'b1;
    i_req[0] = 1'b1; i_addr[0] = 32'hBFC0_0000;
    step(); #3;
    chk("rst_i_gnt", {31'd0, i_gnt[0]}, 32'd0);
    chk("rst_stall_if", {31'd0, stallreq_if[0]}, 32'd0);
    step(); rst = 1'b0; #3;
    chk("post_rst_outs", outs_or(0), 32'd0);
    step(); clr();

    // instruction stream, RD_LAT=1
    step(); i_req[0] = 1'b1; i_addr[0] = 32'hBFC0_0000; #3;
    chk("if0_gnt", {31'd0, i_gnt[0]}, 32'd1);
    chk("if0_addr", sram_addr[0], 32'hBFC0_0000);
    chk("if0_we", {28'd0, sram_we[0]}, 32'd0);
    chk("if0_stall", {31'd0, stallreq_if[0]}, 32'd0);
    push(0, 1'b0, 32'h2401_0001);
    step(); i_addr[0] = 32'hBFC0_0004; #3;
    chk("if1_gnt", {31'd0, i_gnt[0]}, 32'd1);
    chk("if1_addr", sram_addr[0], 32'hBFC0_0004);
    push(0, 1'b0, 32'h2402_0002);
    step(); clr();
    step();

    // starvation: d wins four cycles, then i
    for (int c = 0; c < 4; c++) begin
      step();
      i_req[0] = 1'b1; i_addr[0] = 32'hBFC0_0008;
      d_req[0] = 1'b1; d_addr[0] = 32'h8000_0010; #3;
      chk("starve_d_gnt", {31'd0, d_gnt[0]}, 32'd1);
      chk("starve_i_gnt", {31'd0, i_gnt[0]}, 32'd0);
      chk("starve_stall_if", {31'd0, stallreq_if[0]}, 32'd1);
      push(0, 1'b1, 32'h25A5_A5B5);
    end
    step(); #3;
    chk("starve_i_wins", {31'd0, i_gnt[0]}, 32'd1);
    chk("starve_d_refused", {31'd0, d_gnt[0]}, 32'd0);
    chk("starve_stall_mem", {31'd0, stallreq_mem[0]}, 32'd1);
    push(0, 1'b0, 32'h1A65_A5AD);
    step(); #3;
    chk("starve_cleared_d_gnt", {31'd0, d_gnt[0]}, 32'd1);
    push(0, 1'b1, 32'h25A5_A5B5);
    step(); clr();
    step();

    // byte write
    step(); d_req[0] = 1'b1; d_we[0] = 4'b0011;
    d_addr[0] = 32'h8000_1000; d_wdata[0] = 32'hDEAD_BEEF; #3;
    chk("wr_gnt", {31'd0, d_gnt[0]}, 32'd1);
    chk("wr_en", {31'd0, sram_en[0]}, 32'd1);
    chk("wr_we", {28'd0, sram_we[0]}, 32'h3);
    chk("wr_addr", sram_addr[0], 32'h8000_1000);
    chk("wr_data", sram_wdata[0], 32'hDEAD_BEEF);
    step(); clr();
    step();

    // RD_LAT=3: no grants while busy, grant again in completion cycle
    step(); d_req[2] = 1'b1; d_addr[2] = 32'h8000_0020;
    i_req[2] = 1'b1; i_addr[2] = 32'hBFC0_0010; #3;
    chk("lat3_d_gnt", {31'd0, d_gnt[2]}, 32'd1);
    chk("lat3_i_gnt0", {31'd0, i_gnt[2]}, 32'd0);
    push(2, 1'b1, 32'h25A5_A585);
    for (int c = 0; c < 2; c++) begin
      step(); d_req[2] = 1'b0; #3;
      chk("lat3_busy_i_gnt", {31'd0, i_gnt[2]}, 32'd0);
      chk("lat3_busy_en", {31'd0, sram_en[2]}, 32'd0);
      chk("lat3_stall_if", {31'd0, stallreq_if[2]}, 32'd1);
      chk("lat3_stall_mem", {31'd0, stallreq_mem[2]}, 32'd1);
    end
    step(); #3;
    chk("lat3_done_i_gnt", {31'd0, i_gnt[2]}, 32'd1);
    chk("lat3_done_d_rvalid", {31'd0, d_rvalid[2]}, 32'd1);
    chk("lat3_done_stall_mem", {31'd0, stallreq_mem[2]}, 32'd0);
    push(2, 1'b0, 32'h1A65_A5B5);
    step(); clr();
    step(); step(); step();

    // RD_LAT=2: flush squashes outstanding instruction read
    step(); i_req[1] = 1'b1; i_addr[1] = 32'hBFC0_0020; #3;
    chk("fl_i_gnt", {31'd0, i_gnt[1]}, 32'd1);
    step(); i_req[1] = 1'b0; flush[1] = 1'b1; #3;
    chk("fl_busy_en", {31'd0, sram_en[1]}, 32'd0);
    step(); flush[1] = 1'b0; d_req[1] = 1'b1; d_addr[1] = 32'h8000_0030; #3;
    chk("fl_d_gnt", {31'd0, d_gnt[1]}, 32'd1);
    chk("fl_i_rvalid", {31'd0, i_rvalid[1]}, 32'd0);
    push(1, 1'b1, 32'h25A5_A595);
    step(); d_req[1] = 1'b0; #3;
    chk("fl_stall_mem", {31'd0, stallreq_mem[1]}, 32'd1);
    step(); #3;
    chk("fl_d_rvalid", {31'd0, d_rvalid[1]}, 32'd1);
    step(); clr();

    // reset while busy (RD_LAT=3)
    step(); d_req[2] = 1'b1; d_addr[2] = 32'h8000_0040; #3;
    chk("rb_d_gnt", {31'd0, d_gnt[2]}, 32'd1);
    step(); rst = 1'b1; d_req[2] = 1'b0; #3;
    chk("rb_in_rst_outs", outs_or(2), 32'd0);
    step(); rst = 1'b0; #3;
    chk("rb_after_rst_outs", outs_or(2), 32'd0);
    step(); i_req[2] = 1'b1; i_addr[2] = 32'hBFC0_0030; #3;
    chk("rb_idle_i_gnt", {31'd0, i_gnt[2]}, 32'd1);
    chk("rb_idle_stall_mem", {31'd0, stallreq_mem[2]}, 32'd0);
    push(2, 1'b0, 32'h1A65_A595);
    step(); clr();
    step(); step(); step(); step();

    chk("sb_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
